// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared sizes, queue entry type and helpers for the ALU issue scheduler.
package alu_sched_pkg;
    localparam int NQ         = 8;
    localparam int LNQ        = 3;
    localparam int NALU       = 2;
    localparam int CNTRL_SIZE = 7;
    localparam int NCOMMIT    = 32;
    localparam int LNCOMMIT   = 5;
    localparam int NWB        = 2;
    // only this pipe carries combined-branch logic
    localparam int BRANCH_ALU = 0;

    typedef struct packed {
        logic                  valid;
        logic [CNTRL_SIZE-1:0] control;
        logic [LNCOMMIT-1:0]   rd;
        logic                  makes_rd;
        logic                  needs_rs2;
        logic                  is_branch;
        logic [LNCOMMIT-1:0]   rs1_tag;
        logic                  rs1_rdy;
        logic [LNCOMMIT-1:0]   rs2_tag;
        logic                  rs2_rdy;
    } sched_entry_t;

    function automatic logic entry_ready(sched_entry_t e);
        return e.valid && e.rs1_rdy && (e.rs2_rdy || !e.needs_rs2);
    endfunction

    function automatic logic wb_hit(logic [NWB-1:0] v, logic [NWB*LNCOMMIT-1:0] rd, logic [LNCOMMIT-1:0] tag);
        wb_hit = 1'b0;
        for (int i = 0; i < NWB; i++)
            wb_hit = wb_hit || (v[i] && rd[i*LNCOMMIT +: LNCOMMIT] == tag);
    endfunction
endpackage

// File: rtl/alu_issue_sched_if.sv
// alu_issue_sched_if: dispatch, wakeup, kill and issue signals of the ALU issue scheduler.
interface alu_issue_sched_if;
    import alu_sched_pkg::*;
    logic                            in_valid;
    logic                            in_ready;
    logic [CNTRL_SIZE-1:0]           in_control;
    logic [LNCOMMIT-1:0]             in_rd;
    logic                            in_makes_rd;
    logic                            in_needs_rs2;
    logic                            in_is_branch;
    logic [LNCOMMIT-1:0]             in_rs1_tag;
    logic [LNCOMMIT-1:0]             in_rs2_tag;
    logic                            in_rs1_rdy;
    logic                            in_rs2_rdy;
    logic [NWB-1:0]                  wb_valid;
    logic [NWB*LNCOMMIT-1:0]         wb_rd;
    logic [NCOMMIT-1:0]              commit_kill;
    logic [NALU-1:0]                 iss_enable;
    logic [NALU*CNTRL_SIZE-1:0]      iss_control;
    logic [NALU*LNCOMMIT-1:0]        iss_rd;
    logic [NALU-1:0]                 iss_makes_rd;
    logic [NALU-1:0]                 iss_needs_rs2;
    logic [NALU-1:0]                 iss_is_branch;
    logic [LNQ:0]                    count;

    modport slave (
        input  in_valid, in_control, in_rd, in_makes_rd, in_needs_rs2, in_is_branch,
               in_rs1_tag, in_rs2_tag, in_rs1_rdy, in_rs2_rdy, wb_valid, wb_rd, commit_kill,
        output in_ready, iss_enable, iss_control, iss_rd, iss_makes_rd, iss_needs_rs2,
               iss_is_branch, count
    );
    modport master (
        output in_valid, in_control, in_rd, in_makes_rd, in_needs_rs2, in_is_branch,
               in_rs1_tag, in_rs2_tag, in_rs1_rdy, in_rs2_rdy, wb_valid, wb_rd, commit_kill,
        input  in_ready, iss_enable, iss_control, iss_rd, iss_makes_rd, iss_needs_rs2,
               iss_is_branch, count
    );
endinterface

// File: rtl/alu_sched_pick.sv
// alu_sched_pick: oldest-first picker; one pick may be a branch, the other excludes branches and the first pick.
module alu_sched_pick
    import alu_sched_pkg::*;
(
    input  logic [NQ-1:0] i_rdy,
    input  logic [NQ-1:0] i_branch,
    output logic [NQ-1:0] o_sel_br,
    output logic [NQ-1:0] o_sel_nb
);
    logic [NQ-1:0] w_nb;
    assign o_sel_br = i_rdy & (~i_rdy + 1'b1);
    assign w_nb     = i_rdy & ~i_branch & ~o_sel_br;
    assign o_sel_nb = w_nb & (~w_nb + 1'b1);
endmodule

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: compacting oldest-first issue queue feeding the integer ALU pipes.
module alu_issue_sched
    import alu_sched_pkg::*;
(
    input logic              clk,
    input logic              reset,
    alu_issue_sched_if.slave bus
);
    sched_entry_t                    r_q [NQ];
    sched_entry_t                    w_nq [NQ];
    sched_entry_t                    w_in;
    logic [LNQ:0]                    r_count, w_k;
    logic                            r_in_ready;
    logic [NALU-1:0]                 r_en, r_makes_rd, r_needs_rs2, r_is_branch;
    logic [NALU-1:0][CNTRL_SIZE-1:0] r_control;
    logic [NALU-1:0][LNCOMMIT-1:0]   r_rd;
    logic [NQ-1:0]                   w_rdy, w_br, w_kill;
    logic [NQ-1:0]                   w_sel [NALU];

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            w_kill[i] = r_q[i].valid && bus.commit_kill[r_q[i].rd];
            w_rdy[i]  = entry_ready(r_q[i]) && !w_kill[i];
            w_br[i]   = r_q[i].is_branch;
        end
    end

    alu_sched_pick u_pick (
        .i_rdy    (w_rdy),
        .i_branch (w_br),
        .o_sel_br (w_sel[BRANCH_ALU]),
        .o_sel_nb (w_sel[1-BRANCH_ALU])
    );

    // survivors pack down in age order, the accepted op lands right behind them
    always_comb begin
        w_in           = '0;
        w_in.valid     = 1'b1;
        w_in.control   = bus.in_control;
        w_in.rd        = bus.in_rd;
        w_in.makes_rd  = bus.in_makes_rd;
        w_in.needs_rs2 = bus.in_needs_rs2;
        w_in.is_branch = bus.in_is_branch;
        w_in.rs1_tag   = bus.in_rs1_tag;
        w_in.rs2_tag   = bus.in_rs2_tag;
        w_in.rs1_rdy   = bus.in_rs1_rdy || wb_hit(bus.wb_valid, bus.wb_rd, bus.in_rs1_tag);
        w_in.rs2_rdy   = bus.in_rs2_rdy || wb_hit(bus.wb_valid, bus.wb_rd, bus.in_rs2_tag);
        w_k            = '0;
        for (int i = 0; i < NQ; i++)
            w_nq[i] = '0;
        for (int i = 0; i < NQ; i++) begin
            if (r_q[i].valid && !w_kill[i] && !w_sel[0][i] && !w_sel[1][i]) begin
                w_nq[w_k[LNQ-1:0]]         = r_q[i];
                w_nq[w_k[LNQ-1:0]].rs1_rdy = r_q[i].rs1_rdy || wb_hit(bus.wb_valid, bus.wb_rd, r_q[i].rs1_tag);
                w_nq[w_k[LNQ-1:0]].rs2_rdy = r_q[i].rs2_rdy || wb_hit(bus.wb_valid, bus.wb_rd, r_q[i].rs2_tag);
                w_k = w_k + 1'b1;
            end
        end
        if (bus.in_valid && r_in_ready && !bus.commit_kill[bus.in_rd]) begin
            w_nq[w_k[LNQ-1:0]] = w_in;
            w_k = w_k + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NQ; i++)
                r_q[i] <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_en        <= '0;
            r_makes_rd  <= '0;
            r_needs_rs2 <= '0;
            r_is_branch <= '0;
            r_control   <= '0;
            r_rd        <= '0;
        end else begin
            r_q        <= w_nq;
            r_count    <= w_k;
            r_in_ready <= w_k < (LNQ+1)'(NQ);
            for (int p = 0; p < NALU; p++) begin
                r_en[p] <= |w_sel[p];
                for (int i = 0; i < NQ; i++) begin
                    if (w_sel[p][i]) begin
                        r_control[p]   <= r_q[i].control;
                        r_rd[p]        <= r_q[i].rd;
                        r_makes_rd[p]  <= r_q[i].makes_rd;
                        r_needs_rs2[p] <= r_q[i].needs_rs2;
                        r_is_branch[p] <= r_q[i].is_branch;
                    end
                end
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.count         = r_count;
    assign bus.iss_enable    = r_en;
    assign bus.iss_control   = r_control;
    assign bus.iss_rd        = r_rd;
    assign bus.iss_makes_rd  = r_makes_rd;
    assign bus.iss_needs_rs2 = r_needs_rs2;
    assign bus.iss_is_branch = r_is_branch;
endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Per-cluster issue scheduler for the integer ALUs.
- Holds up to NQ renamed ALU/branch ops until their source commit-register tags have been written back, then selects the oldest ready ops and issues them to NALU ALU pipes.
- ALU 0 is the only pipe that takes branch ops, because it is the only one with combined-branch logic.
- Sits between rename/dispatch and the ALU instances. It removes killed ops on commit_kill.

Parameters:
- NQ, 8, queue entries
- LNQ, 3, log2(NQ)
- NALU, 2, issue pipes; fixed at 2 in this revision
- CNTRL_SIZE, 7, ALU control width
- NCOMMIT, 32, commit registers
- LNCOMMIT, 5, log2(NCOMMIT)
- NWB, 2, writeback wakeup ports

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- in_valid  in  1  dispatch offers an op
- in_ready  out  1  scheduler can accept this cycle
- in_control  in  CNTRL_SIZE  ALU control word
- in_rd  in  LNCOMMIT  destination commit reg
- in_makes_rd  in  1  op writes rd
- in_needs_rs2  in  1  op uses rs2; when 0, rs2 is treated as ready
- in_is_branch  in  1  branch op; issues on ALU 0 only
- in_rs1_tag, in_rs2_tag  in  LNCOMMIT each  source tags
- in_rs1_rdy, in_rs2_rdy  in  1 each  source already available
- wb_valid  in  NWB  writeback tag valid
- wb_rd  in  NWB*LNCOMMIT  writeback tags
- commit_kill  in  NCOMMIT  bit k kills any op with rd==k
- iss_enable  out  NALU  issue valid per pipe
- iss_control  out  NALU*CNTRL_SIZE
- iss_rd  out  NALU*LNCOMMIT
- iss_makes_rd, iss_needs_rs2, iss_is_branch  out  NALU each
- count  out  LNQ+1  occupied entries

Behaviour:
- Reset (asynchronous, while reset==0):
  - all entries invalid; count=0; in_ready=1
  - iss_enable=0; all other iss_* outputs = 0
- Storage: compacting queue. Entry 0 is always the oldest. Valid entries are contiguous from 0.
- Per entry: valid, control, rd, makes_rd, needs_rs2, is_branch, rs1_tag, rs1_rdy, rs2_tag, rs2_rdy.
- Enqueue:
  - Occurs when in_valid && in_ready && !commit_kill[in_rd].
  - The op is written at index count after compaction, i.e. behind the survivors.
  - If commit_kill[in_rd]=1 in the same cycle, the op is dropped silently.
- in_ready:
  - Registered; equals (next count < NQ).
  - Issue in the current cycle does not give same-cycle credit.
  - When count==NQ, in_ready=0 and in_valid is ignored.
- Wakeup:
  - Any wb port with wb_valid[i] && wb_rd[i]==tag sets that source's rdy bit on the next edge.
  - This applies to stored entries and to the op being enqueued, whose rdy bit is the OR of the input rdy and a wb match.
  - An entry is ready when rs1_rdy && (rs2_rdy || !needs_rs2), using registered state only. There is no same-cycle wb-to-select bypass.
- Select (combinational on registered state):
  - ALU 0 takes the lowest-index ready, unkilled entry, branch or not.
  - ALU 1 takes the lowest-index ready, unkilled, non-branch entry other than ALU 0's pick.
  - An entry is killed when commit_kill[rd]=1 this cycle.
- Issue:
  - Selected fields are registered onto iss_*; iss_enable is high for exactly one cycle per op.
  - Latency: an entry that becomes ready on edge N issues with iss_enable high after edge N+1. Minimum enqueue-to-issue latency is 1 cycle when sources are ready at enqueue.
  - iss_* fields when iss_enable=0 hold their previous values.
- Removal:
  - Issued entries and entries with commit_kill[rd]=1 are invalidated.
  - Survivors shift down, preserving age order.
  - count_next = count - removed + enqueued.
- Simultaneous events:
  - Kill beats select: a killed entry is never issued, even if it is the oldest ready.
  - Wakeup and kill on the same entry: the entry is removed.
- No stall input: the ALUs accept every issue.
- Mid-operation reset clears everything immediately; in-flight iss_enable drops asynchronously.

Decomposition:
- Shared package (alu_sched_pkg):
  - typedef sched_entry_t (fields listed under Storage)
  - constants: NQ, NALU, the ALU-0-only branch rule
  - function entry_ready(entry)
- One natural sub-module: alu_sched_pick, a priority picker over NQ ready/is_branch vectors returning the two one-hot selects (ALU 1 excludes branches and ALU 0's pick).

Test Plan:
- Reset, then enqueue an op with rd=5, both sources ready: iss_enable[0]=1 one cycle later with iss_rd[0]=5; count returns 0.
- Enqueue op A (rs1_tag=3, not ready), then B (ready), then drive wb_rd=3 valid: B issues first on ALU 0. The cycle after wb, A issues on ALU 0.
- Fill 8 entries, none ready: in_ready=0 and a 9th in_valid is ignored. Wake 2 entries: both issue on ALU 0/1 in the same cycle, and in_ready=1 the following cycle with count=6.
- Queue contents: branch (ready) at index 0, two ready ALU ops. ALU 0 gets the branch and ALU 1 gets the older ALU op. With two ready branches only, just ALU 0 issues each cycle.
- Assert commit_kill[7] while the entry with rd=7 is the oldest ready: no issue for rd=7, the younger ready op is selected instead, count drops by the kill plus the issue.
- Assert reset low mid-stream with 4 entries queued: iss_enable=0 and count=0 immediately. After release, a fresh enqueue issues normally.
